// File: rtl/mem_mirrored_dp_pkg.sv
// Shared constants and types for the mirrored dual-port work RAM.
package mem_mirrored_dp_pkg;

  // Bus-wide defaults.
  localparam int unsigned BUS_REG_WIDTH  = 8;
  localparam int unsigned BUS_ADDR_WIDTH = 16;

  // Legal read pipeline depths.
  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  // Work-RAM decode window ($0000-$1FFF).
  localparam logic [BUS_ADDR_WIDTH-1:0] WRAM_BASE_ADDR   = 16'h0000;
  localparam int unsigned               WRAM_WINDOW_LOG2 = 13;

  // Clear-sweep controller states.
  typedef enum logic {
    StClear,
    StIdle
  } clr_state_e;

endpackage

// File: rtl/mem_mirrored_dp_rd_pipe.sv
// Valid/hit/data delay line for one read port.
// Payload registers load only with valid, so outputs hold between pulses.
module mem_mirrored_dp_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic                  i_hit,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_hit,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid [LATENCY];
  logic                  r_hit   [LATENCY];
  logic [DATA_WIDTH-1:0] r_data  [LATENCY];

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    logic                  w_valid;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_data;

    if (s == 0) begin : g_head
      assign w_valid = i_valid;
      assign w_hit   = i_hit;
      assign w_data  = i_data;
    end else begin : g_tail
      assign w_valid = r_valid[s-1];
      assign w_hit   = r_hit[s-1];
      assign w_data  = r_data[s-1];
    end

    // Shift valid every cycle; capture hit/data only alongside a valid.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_valid[s] <= 1'b0;
        r_hit[s]   <= 1'b0;
        r_data[s]  <= '0;
      end else begin
        r_valid[s] <= w_valid;
        if (w_valid) begin
          r_hit[s]  <= w_hit;
          r_data[s] <= w_data;
        end
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_hit   = r_hit[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/mem_mirrored_dp.sv
// Work RAM: port A read/write, port B read-only, mirrored decode window,
// self-clearing sweep after reset, read latency of 1 or 2.
module mem_mirrored_dp
  import mem_mirrored_dp_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = BUS_REG_WIDTH,
  parameter int unsigned           ADDR_WIDTH   = BUS_ADDR_WIDTH,
  parameter int unsigned           DEPTH_LOG2   = 11,
  parameter int unsigned           WINDOW_LOG2  = WRAM_WINDOW_LOG2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = WRAM_BASE_ADDR,
  parameter int unsigned           READ_LATENCY = READ_LATENCY_MIN,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_rvalid,
  output logic                  a_hit,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_rvalid,
  output logic                  b_hit
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  clr_state_e            r_state;
  logic [DEPTH_LOG2-1:0] r_clr_idx;
  logic                  r_busy;

  logic                  w_a_hit, w_b_hit;
  logic [DEPTH_LOG2-1:0] w_a_idx, w_b_idx;
  logic                  w_a_wr, w_a_rd, w_b_rd;
  logic [DATA_WIDTH-1:0] w_a_rdata, w_b_rdata;

  // Window decode; index bits between DEPTH_LOG2 and WINDOW_LOG2 are ignored (mirroring).
  assign w_a_hit = (a_addr[ADDR_WIDTH-1:WINDOW_LOG2] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_LOG2]);
  assign w_b_hit = (b_addr[ADDR_WIDTH-1:WINDOW_LOG2] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_LOG2]);
  assign w_a_idx = a_addr[DEPTH_LOG2-1:0];
  assign w_b_idx = b_addr[DEPTH_LOG2-1:0];

  // Requests are ignored entirely while the sweep owns the array.
  assign w_a_wr = !r_busy && a_req && a_we && w_a_hit;
  assign w_a_rd = !r_busy && a_req && !a_we;
  assign w_b_rd = !r_busy && b_req;

  // Misses read as zero; B sees a same-cycle A write to its index (write-first).
  assign w_a_rdata = w_a_hit ? r_mem[w_a_idx] : '0;
  assign w_b_rdata = !w_b_hit                       ? '0    :
                     (w_a_wr && w_a_idx == w_b_idx) ? a_din : r_mem[w_b_idx];

  // Clear-sweep FSM: one word per cycle, then idle until the next reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        StClear: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == '1) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Array write port: sweep has priority, otherwise decoded port A writes.
  always_ff @(posedge clk) begin
    if (r_busy) begin
      r_mem[r_clr_idx] <= CLEAR_VALUE;
    end else if (w_a_wr) begin
      r_mem[w_a_idx] <= a_din;
    end
  end

  assign busy = r_busy;

  mem_mirrored_dp_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_a_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_a_rd),
    .i_hit   (w_a_hit),
    .i_data  (w_a_rdata),
    .o_valid (a_rvalid),
    .o_hit   (a_hit),
    .o_data  (a_dout)
  );

  mem_mirrored_dp_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_b_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_b_rd),
    .i_hit   (w_b_hit),
    .i_data  (w_b_rdata),
    .o_valid (b_rvalid),
    .o_hit   (b_hit),
    .o_data  (b_dout)
  );

endmodule

// File: doc/mem_mirrored_dp.md
Name: mem_mirrored_dp

Overview:
Parametrised successor to the single-port system RAM: one read/write port (CPU) and one read-only port (DMA/PPU fetch) onto one shared array. The array sits behind a decoded, mirrored address window. On leaving reset it self-clears through an internal sweep state machine. Read latency is selectable. It plugs into the bus fabric in place of the plain RAM for the $0000-$1FFF work-RAM region.

Parameters:
DATA_WIDTH, `REG_WIDTH (8), width of each memory word.
ADDR_WIDTH, `ADDR_WIDTH (16), width of the bus address.
DEPTH_LOG2, 11, log2 of physical words (2 KiB).
WINDOW_LOG2, 13, log2 of the decoded window size; the array repeats (mirrors) inside this window.
BASE_ADDR, 16'h0000, window base; must be aligned to 2^WINDOW_LOG2.
READ_LATENCY, 1, read pipeline depth; legal values are 1 or 2.
CLEAR_VALUE, 8'h00, word written to every entry during the clear sweep.

Ports:
clk  in  1  system clock (phi0 domain)
reset_n  in  1  asynchronous active-low reset
busy  out  1  high while in reset or during the clear sweep
a_req  in  1  port A access request
a_we  in  1  port A write enable (qualified by a_req)
a_addr  in  ADDR_WIDTH  port A address
a_din  in  DATA_WIDTH  port A write data
a_dout  out  DATA_WIDTH  port A read data
a_rvalid  out  1  port A read data valid, a one-cycle pulse
a_hit  out  1  registered with a_rvalid: the address fell inside the window
b_req  in  1  port B read request
b_addr  in  ADDR_WIDTH  port B address
b_dout  out  DATA_WIDTH  port B read data
b_rvalid  out  1  port B read data valid, a one-cycle pulse
b_hit  out  1  registered with b_rvalid: the address fell inside the window

Behaviour:
- Reset (async assert, sync-released internally):
  - Outputs: a_dout=0, b_dout=0, a_rvalid=0, b_rvalid=0, a_hit=0, b_hit=0, busy=1.
  - Pipelines flush; the FSM enters CLEAR with sweep counter = 0.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes CLEAR_VALUE at counter index, one word per clk. Counter increments each cycle.
  - CLEAR -> IDLE on the cycle after index 2^DEPTH_LOG2-1 is written, so the sweep takes exactly 2^DEPTH_LOG2 cycles.
  - busy falls on entry to IDLE.
  - IDLE has no exit other than reset. Reset mid-sweep restarts the sweep from 0.
- While busy=1, a_req and b_req are ignored: no write, no rvalid pulse.
- Decode:
  - hit = (addr[ADDR_WIDTH-1:WINDOW_LOG2] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_LOG2]).
  - index = addr[DEPTH_LOG2-1:0]; bits WINDOW_LOG2-1..DEPTH_LOG2 are don't-care (mirroring).
- Port A write: a_req & a_we & hit commits a_din at the rising edge. No rvalid pulse is generated. A miss write is dropped silently.
- Port A read (a_req & !a_we) and port B read (b_req):
  - rvalid pulses exactly READ_LATENCY cycles after the request edge.
  - dout = array[index] on a hit, 0 on a miss; hit is reported alongside.
  - dout holds its last value when rvalid=0.
- Back-to-back requests are accepted every cycle; throughput is one per port per cycle. No backpressure.
- Collision: a port A write and a port B read to the same index in the same cycle returns the new data on B (write-first). A same-cycle port A read of its own write address cannot occur (a_we is exclusive).
- READ_LATENCY=2 adds one output register stage; data and hit travel together with rvalid.

Decomposition:
- Shared package gains READ_LATENCY_MIN/MAX constants, the work-RAM base/window constants (BASE_ADDR, WINDOW_LOG2), and a two-state clr_state enum (CLEAR, IDLE).
- Natural sub-module: mem_rd_pipe, a parametrised valid/data/hit delay line of depth READ_LATENCY, instantiated once per read port.
- Decode logic and FSM stay in the top module.

Test Plan:
- Reset, then count cycles -> busy=1 for exactly 2048 cycles after reset_n rises. A read of 16'h0123 afterwards returns 8'h00 with a_hit=1.
- Write 8'hA5 to 16'h0005, then read 16'h0805, 16'h1005 and 16'h1805 on port B -> each returns 8'hA5 with b_hit=1 one cycle later (READ_LATENCY=1).
- Read 16'h2000 on port A -> a_rvalid pulses with a_dout=8'h00 and a_hit=0. Write 8'h3C to 16'h4000 -> array unchanged (verified by reading 16'h0000 = 8'h00).
- Same cycle: A writes 8'h77 to 16'h0042 while B reads 16'h0842 -> b_dout=8'h77.
- READ_LATENCY=2: issue A reads on 3 consecutive cycles to 16'h0001, 16'h0002, 16'h0003 (preloaded 8'h11, 8'h22, 8'h33) -> a_rvalid is high on cycles +2, +3, +4 with data in order.
- Assert reset_n low at sweep index 1000, release -> busy stays high a full 2048 cycles. All outputs read 0 during reset; requests during busy produce no rvalid.
